// File: rtl/ser_det_pkg.sv
// Shared types and constants for the serial-detect scheduler (ser_det_sched).
// The optional per-requester hit counters are enabled with SER_DET_HIT_CNT_EN.
package ser_det_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] DEFAULT_PATTERN = 8'hE5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Width of a requester ID; never narrower than one bit.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ser_det_sched_if.sv
// Requester-side bus of the serial-detect scheduler.
//
// Handshake: REQ[i] is requester i's valid; it is a level held until GNT[i]
// and DIN[8i+7:8i] must be stable while it is high. GNT[i] is a one-cycle
// ready-and-taken pulse: the byte transfers in exactly the cycle GNT[i] is
// high, after which the requester may drop REQ[i] or present a new byte.
interface ser_det_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   REQ;
    logic [NREQ*8-1:0] DIN;
    logic [NREQ-1:0]   GNT;

    modport master (output REQ, output DIN, input GNT);
    modport slave  (input REQ, input DIN, output GNT);
endinterface

// File: rtl/ser_det_core.sv
// Serial pattern detector: 8-bit history shift register plus comparator.
// History persists across frames; the hit flag is sticky until clr_flag.
module ser_det_core
    import ser_det_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic sbit,
    input  logic clr_flag,
    output logic hit
);

    logic [BYTE_W-1:0] history;
    logic [BYTE_W-1:0] history_nxt;

    // Next history value: oldest bit falls off the MSB end.
    always_comb begin
        history_nxt = {history[BYTE_W-2:0], sbit};
    end

    // Shift on valid bits only; set the frame flag on a match, clear on report.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            history <= '0;
            hit     <= 1'b0;
        end else begin
            if (en) begin
                history <= history_nxt;
                if (history_nxt == PATTERN) begin
                    hit <= 1'b1;
                end
            end
            if (clr_flag) begin
                hit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ser_det_sched.sv
// Round-robin scheduler sharing one parallel-to-serial shifter and serial
// pattern detector among NREQ byte requesters. Frame = 1 grant cycle,
// 8 shift cycles (MSB first), 1 report cycle.
// Optional feature: define SER_DET_HIT_CNT_EN to add HITCNT, a saturating
// per-requester count of frames that reported a hit.
module ser_det_sched
    import ser_det_pkg::*;
#(
    parameter int                NREQ    = 4,
    parameter logic [BYTE_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int                CNTW    = 8,
    localparam int               GIDW    = gid_width(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    ser_det_sched_if.slave       bus,
    output logic                 BUSY,
    output logic                 SOUT,
    output logic                 SVALID,
    output logic                 DONE,
    output logic                 HIT,
    output logic [GIDW-1:0]      GID,
    output state_t               dbg_state
`ifdef SER_DET_HIT_CNT_EN
    ,
    output logic [NREQ*CNTW-1:0] HITCNT
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [GIDW-1:0]   ptr;
    logic [BYTE_W-1:0] sreg;
    logic [2:0]        bcnt;

    logic              win_found;
    logic [GIDW-1:0]   win_idx;
    logic [GIDW-1:0]   cidx;
    int                cand;
    logic              load;
    logic [NREQ-1:0]   gnt;
    logic              core_hit;

    logic [BYTE_W-1:0] din_b [NREQ];

    // Split the flat DIN bus into one byte per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_din
        assign din_b[i] = bus.DIN[i*BYTE_W +: BYTE_W];
    end

    // Round-robin arbitration: first set REQ searching upward from ptr+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cidx      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cidx = GIDW'(cand);
            if (!win_found && bus.REQ[cidx]) begin
                win_found = 1'b1;
                win_idx   = cidx;
            end
        end
    end

    // FSM next state and grant; grants only in IDLE and never during reset.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !RST) begin
                    gnt       = NREQ'(1) << win_idx;
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bcnt == 3'd7) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture the winner's byte on grant, then shift MSB-first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr  <= GIDW'(NREQ - 1);
            sreg <= '0;
            bcnt <= '0;
        end else if (load) begin
            ptr  <= win_idx;
            sreg <= din_b[win_idx];
            bcnt <= '0;
        end else if (state == SHIFT) begin
            sreg <= {sreg[BYTE_W-2:0], 1'b0};
            bcnt <= bcnt + 3'd1;
        end
    end

    ser_det_core #(
        .PATTERN (PATTERN)
    ) u_core (
        .CLK      (CLK),
        .RST      (RST),
        .en       (SVALID),
        .sbit     (SOUT),
        .clr_flag (DONE),
        .hit      (core_hit)
    );

    // Outputs are decoded from registered state so reset forces them to 0.
    always_comb begin
        SVALID    = (state == SHIFT);
        DONE      = (state == REPORT);
        SOUT      = SVALID & sreg[BYTE_W-1];
        HIT       = DONE & core_hit;
        GID       = DONE ? ptr : '0;
        BUSY      = SVALID | DONE;
        bus.GNT   = gnt;
        dbg_state = state;
    end

`ifdef SER_DET_HIT_CNT_EN
    logic [CNTW-1:0] hcnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_hcnt
        // Saturating count of hit frames reported for requester i.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                hcnt[i] <= '0;
            end else if (DONE && HIT && (ptr == GIDW'(i)) && (hcnt[i] != {CNTW{1'b1}})) begin
                hcnt[i] <= hcnt[i] + CNTW'(1);
            end
        end
        assign HITCNT[i*CNTW +: CNTW] = hcnt[i];
    end
`endif

endmodule
